// File: rtl/aes_pkg.sv
// Shared AES definitions: key-expansion FSM states, round count, Rcon table
// and GF(2^8) multiply. The multiply also serves the S-box and can be reused
// by MixColumns in the cipher datapath.
package aes_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int NR = 10;

  // Round constant top byte for rounds 1..10; any other index yields 0.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// FIPS-197 S-box, purely combinational.
//   a : input byte
//   s : substituted byte
// Computes the multiplicative inverse as a^254 (0 maps to 0) followed by the
// affine transform, avoiding a 256-entry table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  always_comb begin
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    s    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key expansion, one round key per cycle with valid/ready output.
//   clk, rst  : clock, async active-high reset
//   key,start : cipher key and one-cycle start request (ignored while busy)
//   busy      : expansion in progress
//   rk,rk_idx : current round key and its round index 0..10
//   rk_valid  : rk/rk_idx valid; transfers when rk_ready is also high
//   done      : one-cycle pulse after round key 10 transfers
module aes_key_expand
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key,
  input  logic         start,
  output logic         busy,
  output logic [127:0] rk,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         done
);

  state_t       state;
  logic [31:0]  rot_w3;
  logic [31:0]  sub_w3;
  logic [31:0]  temp;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic         xfer;

  // RotWord: [a0,a1,a2,a3] -> [a1,a2,a3,a0]
  assign rot_w3 = {rk[23:0], rk[31:24]};

  // SubWord: one S-box per byte lane
  aes_sbox u_sbox [3:0] (
    .a (rot_w3),
    .s (sub_w3)
  );

  // Rcon index wraps past 10 only when rk_idx==10, where the result is unused.
  assign temp = sub_w3 ^ {rcon(rk_idx + 4'd1), 24'h0};
  assign w0n  = rk[127:96] ^ temp;
  assign w1n  = rk[95:64]  ^ w0n;
  assign w2n  = rk[63:32]  ^ w1n;
  assign w3n  = rk[31:0]   ^ w2n;

  assign xfer = rk_valid & rk_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rk       <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rk       <= key;
            rk_idx   <= 4'd0;
            rk_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (xfer) begin
            if (rk_idx == 4'(NR)) begin
              // rk keeps the final round key after completion
              rk_valid <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end else begin
              rk     <= {w0n, w1n, w2n, w3n};
              rk_idx <= rk_idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Scoreboard bench for aes_key_expand: expected round keys come from a
// word-level FIPS-197 model and are queued at stimulus time; a negedge
// monitor pops and compares on every output transfer.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key = '0;
  logic         start = 1'b0;
  logic         busy;
  logic [127:0] rk;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready = 1'b1;
  logic         done;

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .start    (start),
    .busy     (busy),
    .rk       (rk),
    .rk_idx   (rk_idx),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] k;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  logic [7:0]   sb [0:255];
  logic [127:0] mdl [0:10];
  logic         rand_mode = 1'b0;
  logic         held_chk = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = xt(aa);
    end
    return p;
  endfunction

  // S-box table: inverse found by exhaustive search, then affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  // Classic 44-word schedule, grouped into 11 round keys.
  task automatic build_model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) mdl[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic push_exp(input logic [127:0] k);
    build_model(k);
    for (int r = 0; r <= 10; r++) q.push_back({4'(r), mdl[r]});
  endtask

  // Issue a start at a negedge; the DUT must be idle at the next posedge.
  task automatic issue(input logic [127:0] k);
    push_exp(k);
    key   = k;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    key   = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(input string nm);
    logic got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    chk({nm, "_done_seen"}, 128'(got), 128'(1));
  endtask

  task automatic wait_idx(input string nm, input logic [3:0] target);
    logic got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (rk_valid && rk_idx == target) got = 1'b1;
    end
    chk({nm, "_idx_reached"}, 128'(got), 128'(1));
  endtask

  // Consumer readiness changes just after each rising edge.
  always @(posedge clk) begin
    #1;
    rk_ready = rand_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
  end

  // Monitor
  logic         p_valid = 1'b0, p_ready = 1'b0, p_x10 = 1'b0;
  logic [127:0] p_rk = '0;
  logic [3:0]   p_idx = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      p_valid = 1'b0;
      p_x10   = 1'b0;
    end else begin
      if (p_valid && !p_ready) begin
        chk("stall_valid", 128'(rk_valid), 128'(1));
        chk("stall_rk", rk, p_rk);
        chk("stall_idx", 128'(rk_idx), 128'(p_idx));
      end
      if (done || p_x10) chk("done_pulse", 128'(done), 128'(p_x10));
      if (held_chk) chk("held_busy", 128'(busy), 128'(!done));
      if (rk_valid && rk_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_key", 128'(rk_idx), 128'hffff);
        end else begin
          e = q.pop_front();
          chk("rk_idx", 128'(rk_idx), 128'(e.idx));
          chk("rk", rk, e.k);
        end
      end
      p_valid = rk_valid;
      p_ready = rk_ready;
      p_rk    = rk;
      p_idx   = rk_idx;
      p_x10   = rk_valid && rk_ready && rk_idx == 4'd10;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int ndone;
    build_sbox();

    // Reset state
    #12;
    chk("rst_rk", rk, 128'h0);
    chk("rst_idx", 128'(rk_idx), 128'h0);
    chk("rst_valid", 128'(rk_valid), 128'h0);
    chk("rst_busy", 128'(busy), 128'h0);
    chk("rst_done", 128'(done), 128'h0);
    @(posedge clk); #3 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Known vectors; idx1/idx10 expectations taken from published values
    push_exp(128'h000102030405060708090a0b0c0d0e0f);
    q[q.size()-10].k = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    q[q.size()-1].k  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    key = 128'h000102030405060708090a0b0c0d0e0f;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 128'(busy), 128'(1));
    chk("start_rk_is_key", rk, 128'h000102030405060708090a0b0c0d0e0f);
    wait_done("vec1");
    chk("vec1_busy_in_done", 128'(busy), 128'(0));
    chk("vec1_rk_held", rk, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("vec1_q_empty", 128'(q.size()), 128'(0));

    // Start accepted in the done cycle
    push_exp(128'h2b7e151628aed2a6abf7158809cf4f3c);
    q[q.size()-10].k = 128'ha0fafe1788542cb123a339392a6c7605;
    q[q.size()-1].k  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("vec2");
    chk("vec2_q_empty", 128'(q.size()), 128'(0));

    // Random keys with random stalls
    rand_mode = 1'b1;
    for (int n = 0; n < 4; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue({$urandom, $urandom, $urandom, $urandom});
      wait_done("rand");
    end
    chk("rand_q_empty", 128'(q.size()), 128'(0));

    // A start mid-expansion with another key is ignored
    issue({$urandom, $urandom, $urandom, $urandom});
    wait_idx("ign", 4'd5);
    key = {$urandom, $urandom, $urandom, $urandom};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign");
    chk("ign_q_empty", 128'(q.size()), 128'(0));
    rand_mode = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of an expansion
    issue({$urandom, $urandom, $urandom, $urandom});
    wait_idx("mid", 4'd4);
    #2 rst = 1'b1;
    #1;
    chk("midrst_rk", rk, 128'h0);
    chk("midrst_idx", 128'(rk_idx), 128'h0);
    chk("midrst_valid", 128'(rk_valid), 128'h0);
    chk("midrst_busy", 128'(busy), 128'h0);
    q.delete();
    @(posedge clk); #3 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("postrst_valid", 128'(rk_valid), 128'h0);
    issue({$urandom, $urandom, $urandom, $urandom});
    wait_done("postrst");
    chk("postrst_q_empty", 128'(q.size()), 128'(0));
    repeat (2) @(negedge clk);

    // start held high: back-to-back expansions
    key = {$urandom, $urandom, $urandom, $urandom};
    for (int n = 0; n < 3; n++) push_exp(key);
    start = 1'b1;
    @(negedge clk);
    held_chk = 1'b1;
    ndone = 0;
    for (int i = 0; i < 200 && ndone < 3; i++) begin
      if (done) ndone++;
      if (ndone < 3) @(negedge clk);
    end
    start = 1'b0;
    held_chk = 1'b0;
    chk("held_done_count", 128'(ndone), 128'(3));
    repeat (3) @(negedge clk);
    chk("held_q_empty", 128'(q.size()), 128'(0));
    chk("held_idle", 128'(busy), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
